// File: rtl/imem_sequencer.sv
// Time-shares the single instruction-memory port between the program loader
// (valid/ready word stream) and the CPU fetch path (pc with branch and halt).
module imem_sequencer #(
    parameter int ADDR_W  = 3,
    parameter int INSTR_W = 12
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               prog_valid,
    input  logic [INSTR_W-1:0] prog_data,
    input  logic               prog_last,
    output logic               prog_ready,
    input  logic               run,
    input  logic               halt,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_target,
    output logic [ADDR_W-1:0]  imem_index,
    output logic [INSTR_W-1:0] imem_wdata,
    output logic               imem_load,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               instr_valid,
    output logic [ADDR_W:0]    prog_count,
    output logic               busy
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;

    localparam int                DEPTH     = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   COUNT_ONE = (ADDR_W + 1)'(1);

    logic [1:0]         state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [ADDR_W-1:0]  load_addr_q, load_addr_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0]  instr_pc_q, instr_pc_d;
    logic               instr_valid_q, instr_valid_d;
    logic [ADDR_W:0]    prog_count_q, prog_count_d;
    logic               transfer_s;

    // Memory port sharing: loader owns the port outside RUN
    always_comb begin
        prog_ready = (state_q != ST_RUN);
        transfer_s = prog_valid & prog_ready;
        imem_load  = transfer_s & ~reset;
        imem_wdata = prog_data;
        if (state_q == ST_RUN) begin
            imem_index = pc_q;
        end else begin
            imem_index = load_addr_q;
        end
        busy = (state_q != ST_IDLE);
    end

    // Next-state logic for load sequencing and fetch
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        load_addr_d   = load_addr_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = 1'b0;
        prog_count_d  = prog_count_q;
        case (state_q)
            ST_IDLE: begin
                if (transfer_s) begin
                    if (prog_last) begin
                        prog_count_d = {1'b0, load_addr_q} + COUNT_ONE;
                        load_addr_d  = '0;
                    end else begin
                        load_addr_d  = load_addr_q + ADDR_ONE;
                        state_d      = ST_LOAD;
                    end
                end else if (run) begin
                    pc_d    = '0;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                // The top address always closes the load so nothing wraps onto word 0
                if (transfer_s) begin
                    if (prog_last || (load_addr_q == LAST_ADDR)) begin
                        prog_count_d = {1'b0, load_addr_q} + COUNT_ONE;
                        load_addr_d  = '0;
                        state_d      = ST_IDLE;
                    end else begin
                        load_addr_d  = load_addr_q + ADDR_ONE;
                    end
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_RUN: begin
                instr_d       = imem_rdata;
                instr_pc_d    = pc_q;
                instr_valid_d = 1'b1;
                if (halt) begin
                    state_d = ST_IDLE;
                end else if (branch_taken) begin
                    pc_d = branch_target;
                end else begin
                    pc_d = pc_q + ADDR_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            pc_q          <= '0;
            load_addr_q   <= '0;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
            // An aborted load keeps the count of the last completed program
            if (state_q != ST_LOAD) begin
                prog_count_q <= '0;
            end
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            load_addr_q   <= load_addr_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            prog_count_q  <= prog_count_d;
        end
    end

    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = instr_valid_q;
    assign prog_count  = prog_count_q;

endmodule

// File: tb/tb_imem_sequencer.sv
// Bench for imem_sequencer: owns an 8x12 memory, compares every cycle against
// a behavioural model of load/run, then runs randomized traffic.
module tb_imem_sequencer;

    localparam int ADDR_W  = 3;
    localparam int INSTR_W = 12;
    localparam int DEPTH   = 8;

    localparam int M_IDLE = 0;
    localparam int M_LOAD = 1;
    localparam int M_RUN  = 2;

    logic               clk;
    logic               reset;
    logic               prog_valid;
    logic [INSTR_W-1:0] prog_data;
    logic               prog_last;
    logic               prog_ready;
    logic               run;
    logic               halt;
    logic               branch_taken;
    logic [ADDR_W-1:0]  branch_target;
    logic [ADDR_W-1:0]  imem_index;
    logic [INSTR_W-1:0] imem_wdata;
    logic               imem_load;
    logic [INSTR_W-1:0] imem_rdata;
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  instr_pc;
    logic               instr_valid;
    logic [ADDR_W:0]    prog_count;
    logic               busy;

    logic [INSTR_W-1:0] mem [DEPTH];

    int n_checks;
    int n_fail;

    // Model state
    int m_mode, m_pc, m_addr, m_count, m_instr, m_ipc, m_valid;
    int ref_mem [DEPTH];

    imem_sequencer #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .prog_valid   (prog_valid),
        .prog_data    (prog_data),
        .prog_last    (prog_last),
        .prog_ready   (prog_ready),
        .run          (run),
        .halt         (halt),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .imem_index   (imem_index),
        .imem_wdata   (imem_wdata),
        .imem_load    (imem_load),
        .imem_rdata   (imem_rdata),
        .instr        (instr),
        .instr_pc     (instr_pc),
        .instr_valid  (instr_valid),
        .prog_count   (prog_count),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory: combinational read, write lands on the clock edge
    assign imem_rdata = mem[imem_index];
    always_ff @(posedge clk) begin
        if (imem_load) mem[imem_index] <= imem_wdata;
    end

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic drv(input bit v, input int d, input bit l, input bit r,
                       input bit h, input bit b, input int t, input bit rst);
        prog_valid    = v;
        prog_data     = INSTR_W'(d);
        prog_last     = l;
        run           = r;
        halt          = h;
        branch_taken  = b;
        branch_target = ADDR_W'(t);
        reset         = rst;
    endtask

    // One clock: check outputs mid-cycle, advance the model, wait past the edge
    task automatic cycle();
        bit xfer;
        int n_mode, n_pc, n_addr, n_count, n_instr, n_ipc, n_valid;
        @(negedge clk);
        xfer = prog_valid && (m_mode != M_RUN);
        check_eq("prog_ready", int'(prog_ready), int'(m_mode != M_RUN));
        check_eq("imem_load", int'(imem_load), int'(xfer && !reset));
        check_eq("imem_index", int'(imem_index), (m_mode == M_RUN) ? m_pc : m_addr);
        if (xfer && !reset) check_eq("imem_wdata", int'(imem_wdata), int'(prog_data));
        check_eq("busy", int'(busy), int'(m_mode != M_IDLE));
        check_eq("instr", int'(instr), m_instr);
        check_eq("instr_pc", int'(instr_pc), m_ipc);
        check_eq("instr_valid", int'(instr_valid), m_valid);
        check_eq("prog_count", int'(prog_count), m_count);

        n_mode = m_mode; n_pc = m_pc; n_addr = m_addr; n_count = m_count;
        n_instr = m_instr; n_ipc = m_ipc; n_valid = 0;
        if (reset) begin
            if (m_mode != M_LOAD) n_count = 0;
            n_mode = M_IDLE; n_pc = 0; n_addr = 0; n_instr = 0; n_ipc = 0;
        end else if (m_mode == M_RUN) begin
            n_instr = ref_mem[m_pc];
            n_ipc   = m_pc;
            n_valid = 1;
            if (halt) n_mode = M_IDLE;
            else if (branch_taken) n_pc = int'(branch_target);
            else n_pc = (m_pc + 1) % DEPTH;
        end else if (xfer) begin
            ref_mem[m_addr] = int'(prog_data);
            if (prog_last || m_addr == DEPTH - 1) begin
                n_count = m_addr + 1;
                n_addr  = 0;
                n_mode  = M_IDLE;
            end else begin
                n_addr  = m_addr + 1;
                n_mode  = M_LOAD;
            end
        end else if (m_mode == M_IDLE && run) begin
            n_mode = M_RUN;
            n_pc   = 0;
        end
        @(posedge clk);
        #1;
        m_mode = n_mode; m_pc = n_pc; m_addr = n_addr; m_count = n_count;
        m_instr = n_instr; m_ipc = n_ipc; m_valid = n_valid;
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        m_mode = M_IDLE; m_pc = 0; m_addr = 0; m_count = 0;
        m_instr = 0; m_ipc = 0; m_valid = 0;
        for (int i = 0; i < DEPTH; i++) begin
            mem[i] = '0;
            ref_mem[i] = 0;
        end
        drv(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1);
        #1;
        cycle();
        cycle();
        drv(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        cycle();

        // Three back-to-back words, last one tagged
        drv(1'b1, 12'hA11, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0); cycle();
        drv(1'b1, 12'hB22, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0); cycle();
        drv(1'b1, 12'hC33, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0); cycle();
        drv(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0); cycle();
        check_eq("cnt_after_abc", int'(prog_count), 3);

        // Eight words with gaps and no last flag: depth terminates the load
        for (int i = 0; i < DEPTH; i++) begin
            drv(1'b1, 12'h100 + i * 17, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0); cycle();
            drv(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0); cycle();
        end
        check_eq("cnt_after_full", int'(prog_count), 8);
        check_eq("busy_after_full", int'(busy), 0);

        // Run through the whole memory and wrap
        drv(1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0); cycle();
        drv(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        for (int i = 0; i < 10; i++) cycle();
        check_eq("run_wrap_pc", int'(instr_pc), 1);
        for (int k = 0; k < 20 && m_pc != 4; k++) cycle();
        drv(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1, 1'b0); cycle();
        drv(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0); cycle();
        check_eq("branch_fetch_pc", int'(instr_pc), 1);
        for (int k = 0; k < 20 && m_pc != 4; k++) cycle();
        drv(1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 6, 1'b0); cycle();
        drv(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0); cycle();
        check_eq("halt_valid_drop", int'(instr_valid), 0);
        check_eq("halt_idle", int'(busy), 0);

        // Load beats run; then reset after two words aborts the load
        drv(1'b1, 12'h5A5, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0); cycle();
        drv(1'b1, 12'h3C3, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0); cycle();
        drv(1'b1, 12'h777, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1); cycle();
        drv(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0); cycle();
        check_eq("abort_keeps_cnt", int'(prog_count), 8);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            drv($urandom_range(1, 0) == 1, int'($urandom_range(4095, 0)),
                $urandom_range(5, 0) == 0, $urandom_range(3, 0) == 0,
                $urandom_range(9, 0) == 0, $urandom_range(4, 0) == 0,
                int'($urandom_range(7, 0)), $urandom_range(49, 0) == 0);
            cycle();
        end
        for (int i = 0; i < DEPTH; i++) check_eq("mem_contents", int'(mem[i]), ref_mem[i]);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
